// File: rtl/irq_pending_latch_pkg.sv
// Shared constants and helpers for the interrupt pending latch and the
// downstream 4-to-2 priority encoder that consumes its Y outputs.
package irq_pending_latch_pkg;

    localparam int NUM_IRQ          = 4;
    localparam int IRQ_IDX_W        = 2;
    localparam int SYNC_STAGES_DEF  = 2;

    typedef struct packed {
        logic pend;
        logic ovf;
    } line_state_t;

    // One-hot decode of an acknowledge index into a per-line select vector.
    function automatic logic [NUM_IRQ-1:0] idx_decode(input logic [IRQ_IDX_W-1:0] idx);
        logic [NUM_IRQ-1:0] v;
        v = {NUM_IRQ{1'b0}};
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/irq_pending_latch_if.sv
// Request/acknowledge bus between the interrupt source side and the pending
// latch; the latch takes the slave modport.
interface irq_pending_latch_if;
    import irq_pending_latch_pkg::*;

    logic [NUM_IRQ-1:0]   req_in;
    logic [NUM_IRQ-1:0]   mask;
    logic                 ack;
    logic [IRQ_IDX_W-1:0] ack_idx;
    logic                 ovf_clr;
    logic                 Y0;
    logic                 Y1;
    logic                 Y2;
    logic                 Y3;
    logic [NUM_IRQ-1:0]   ovf;

    modport master (
        output req_in, mask, ack, ack_idx, ovf_clr,
        input  Y0, Y1, Y2, Y3, ovf
    );

    modport slave (
        input  req_in, mask, ack, ack_idx, ovf_clr,
        output Y0, Y1, Y2, Y3, ovf
    );

endinterface

// File: rtl/irq_pending_latch_sync_ff.sv
// Multi-flop synchronizer for a single asynchronous request line.
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] r_chain;

    // Shift the asynchronous input through the metastability chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_chain <= {STAGES{1'b0}};
        end else begin
            r_chain <= {r_chain[STAGES-2:0], d};
        end
    end

    assign q = r_chain[STAGES-1];

endmodule

// File: rtl/irq_pending_latch.sv
// Synchronizes four request lines, latches rising edges as pending interrupts
// and flags overruns; Y outputs feed the downstream priority encoder.
module irq_pending_latch
    import irq_pending_latch_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    irq_pending_latch_if.slave bus
);

    logic [NUM_IRQ-1:0] w_sync;
    logic [NUM_IRQ-1:0] w_ack_hit;
    logic [NUM_IRQ-1:0] w_pend;
    logic [NUM_IRQ-1:0] w_ovf;

    assign w_ack_hit = idx_decode(bus.ack_idx) & {NUM_IRQ{bus.ack}};

    for (genvar gi = 0; gi < NUM_IRQ; gi++) begin : g_line
        logic        r_hist;
        line_state_t r_state;
        line_state_t w_state_nxt;
        logic        w_rise;

        sync_ff #(
            .STAGES (SYNC_STAGES)
        ) u_sync (
            .clk   (clk),
            .rst_n (rst_n),
            .d     (bus.req_in[gi]),
            .q     (w_sync[gi])
        );

        assign w_rise = w_sync[gi] & ~r_hist;

        // Set beats a same-edge ack; an overrun is only a rise the ack does not absorb.
        always_comb begin
            w_state_nxt = r_state;
            if (w_rise) begin
                w_state_nxt.pend = 1'b1;
            end else if (w_ack_hit[gi]) begin
                w_state_nxt.pend = 1'b0;
            end else begin
                w_state_nxt.pend = r_state.pend;
            end
            if (w_rise && r_state.pend && !w_ack_hit[gi]) begin
                w_state_nxt.ovf = 1'b1;
            end else if (bus.ovf_clr) begin
                w_state_nxt.ovf = 1'b0;
            end else begin
                w_state_nxt.ovf = r_state.ovf;
            end
        end

        // History flop and per-line pending/overrun state.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_hist  <= 1'b0;
                r_state <= '{pend: 1'b0, ovf: 1'b0};
            end else begin
                r_hist  <= w_sync[gi];
                r_state <= w_state_nxt;
            end
        end

        assign w_pend[gi] = r_state.pend;
        assign w_ovf[gi]  = r_state.ovf;
    end

    assign bus.Y0  = w_pend[0] & ~bus.mask[0];
    assign bus.Y1  = w_pend[1] & ~bus.mask[1];
    assign bus.Y2  = w_pend[2] & ~bus.mask[2];
    assign bus.Y3  = w_pend[3] & ~bus.mask[3];
    assign bus.ovf = w_ovf;

endmodule

// File: tb/tb_irq_pending_latch.sv
// Scoreboard bench for irq_pending_latch: stimulus queues expected Y/ovf,
// a negedge monitor pops and compares.
module tb_irq_pending_latch;
    import irq_pending_latch_pkg::*;

    logic clk;
    logic rst_n;

    irq_pending_latch_if u_if ();

    irq_pending_latch #(
        .SYNC_STAGES (2)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if.slave)
    );

    typedef struct {
        string      name;
        logic [3:0] y;
        logic [3:0] ovf;
    } exp_t;

    exp_t q_exp[$];
    exp_t e;
    int   checks;
    int   errors;
    logic [3:0] y_act;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign y_act = {u_if.Y3, u_if.Y2, u_if.Y1, u_if.Y0};

    // Monitor: compare every queued expectation against outputs at the falling edge.
    always @(negedge clk) begin
        while (q_exp.size() > 0) begin
            e = q_exp.pop_front();
            checks = checks + 1;
            if (y_act !== e.y) begin
                errors = errors + 1;
                $display("FAIL %s Y: got %b expected %b", e.name, y_act, e.y);
            end
            checks = checks + 1;
            if (u_if.ovf !== e.ovf) begin
                errors = errors + 1;
                $display("FAIL %s ovf: got %b expected %b", e.name, u_if.ovf, e.ovf);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string nm, input logic [3:0] y, input logic [3:0] o);
        exp_t x;
        x.name = nm;
        x.y    = y;
        x.ovf  = o;
        q_exp.push_back(x);
    endtask

    // One-cycle request pulse, then wait until the third edge has latched it.
    task automatic pulse(input logic [3:0] lines);
        u_if.req_in = lines;
        step();
        u_if.req_in = 4'b0000;
        step();
        step();
    endtask

    task automatic do_ack(input logic [1:0] idx);
        u_if.ack     = 1'b1;
        u_if.ack_idx = idx;
        step();
        u_if.ack     = 1'b0;
        u_if.ack_idx = 2'd0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n          = 1'b0;
        u_if.req_in    = 4'b0000;
        u_if.mask      = 4'b0000;
        u_if.ack       = 1'b0;
        u_if.ack_idx   = 2'd0;
        u_if.ovf_clr   = 1'b0;
        step();
        expect_out("reset", 4'b0000, 4'b0000);
        step();
        rst_n = 1'b1;
        step();

        // Single pulse on line 2, latency then ack.
        u_if.req_in = 4'b0100;
        step();
        u_if.req_in = 4'b0000;
        expect_out("lat_edge1", 4'b0000, 4'b0000);
        step();
        expect_out("lat_edge2", 4'b0000, 4'b0000);
        step();
        expect_out("lat_edge3", 4'b0100, 4'b0000);
        step();
        expect_out("held_pend2", 4'b0100, 4'b0000);
        do_ack(2'd2);
        expect_out("ack2", 4'b0000, 4'b0000);

        // All lines held high for ten cycles: one event each, no overrun.
        u_if.req_in = 4'b1111;
        for (int i = 1; i <= 10; i++) begin
            step();
            if (i == 2) expect_out("all_edge2", 4'b0000, 4'b0000);
            if (i == 3) expect_out("all_edge3", 4'b1111, 4'b0000);
            if (i == 10) expect_out("all_held", 4'b1111, 4'b0000);
        end
        u_if.req_in = 4'b0000;
        do_ack(2'd0);
        expect_out("all_ack0", 4'b1110, 4'b0000);
        do_ack(2'd1);
        expect_out("all_ack1", 4'b1100, 4'b0000);
        do_ack(2'd3);
        expect_out("all_ack3", 4'b0100, 4'b0000);
        do_ack(2'd2);
        expect_out("all_ack2", 4'b0000, 4'b0000);
        step();
        step();
        expect_out("all_no_repend", 4'b0000, 4'b0000);

        // Overrun on line 0, then ovf_clr keeps pend.
        pulse(4'b0001);
        expect_out("ovf_first", 4'b0001, 4'b0000);
        pulse(4'b0001);
        expect_out("ovf_set", 4'b0001, 4'b0001);
        u_if.ovf_clr = 1'b1;
        step();
        u_if.ovf_clr = 1'b0;
        expect_out("ovf_clr", 4'b0001, 4'b0000);
        do_ack(2'd0);
        expect_out("ovf_ack0", 4'b0000, 4'b0000);

        // Masking hides but does not clear; unmask shows in the same cycle.
        u_if.mask = 4'b0010;
        pulse(4'b0010);
        expect_out("masked", 4'b0000, 4'b0000);
        step();
        u_if.mask = 4'b0000;
        expect_out("unmask", 4'b0010, 4'b0000);
        do_ack(2'd3);
        expect_out("ack_other", 4'b0010, 4'b0000);
        do_ack(2'd1);
        expect_out("ack1", 4'b0000, 4'b0000);

        // Ack coinciding with a fresh rise on line 3: re-pend, no overrun.
        pulse(4'b1000);
        expect_out("l3_pend", 4'b1000, 4'b0000);
        u_if.req_in = 4'b1000;
        step();
        u_if.req_in = 4'b0000;
        step();
        u_if.ack     = 1'b1;
        u_if.ack_idx = 2'd3;
        step();
        u_if.ack     = 1'b0;
        expect_out("ack_rise_same", 4'b1000, 4'b0000);
        do_ack(2'd3);
        expect_out("l3_cleared", 4'b0000, 4'b0000);

        // Overrun on the same edge as ovf_clr: overrun wins.
        pulse(4'b0100);
        u_if.req_in = 4'b0100;
        step();
        u_if.req_in = 4'b0000;
        step();
        u_if.ovf_clr = 1'b1;
        step();
        u_if.ovf_clr = 1'b0;
        expect_out("ovf_vs_clr", 4'b0100, 4'b0100);

        // Async reset mid-cycle with lines 0 and 2 pending and ovf[2] set.
        pulse(4'b0001);
        expect_out("pre_reset", 4'b0101, 4'b0100);
        step();
        #2;
        rst_n = 1'b0;
        expect_out("async_reset", 4'b0000, 4'b0000);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) step();
        expect_out("post_reset_idle", 4'b0000, 4'b0000);

        // Release reset with a line already high: exactly one event.
        rst_n = 1'b0;
        u_if.req_in = 4'b0010;
        step();
        rst_n = 1'b1;
        step();
        step();
        expect_out("held_edge2", 4'b0000, 4'b0000);
        step();
        expect_out("held_edge3", 4'b0010, 4'b0000);
        do_ack(2'd1);
        for (int i = 0; i < 3; i++) step();
        expect_out("held_once", 4'b0000, 4'b0000);
        u_if.req_in = 4'b0000;
        step();

        @(negedge clk);
        #1;
        checks = checks + 1;
        if (q_exp.size() != 0) begin
            errors = errors + 1;
            $display("FAIL drain: got %0d queued expected 0", q_exp.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/irq_pending_latch.md
IRQ_PENDING_LATCH -- requirements
Module: irq_pending_latch

Interface
REQ-001 Parameter SYNC_STAGES, default 2, meaning the synchronizer depth per request line; legal range 2-3.
REQ-002 Port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 Port rst_n, input, 1, asynchronous active-low reset.
REQ-004 Port req_in, input, 4, asynchronous request lines; bit i is request i, and bit 3 is highest priority downstream.
REQ-005 Port mask, input, 4, synchronous; 1 suppresses output of pending bit i.
REQ-006 Port ack, input, 1, synchronous one-cycle pulse that clears the pending bit selected by ack_idx.
REQ-007 Port ack_idx, input, 2, index of the line being acknowledged; the encoding matches the downstream encoder's {A,B} output.
REQ-008 Ports Y0, Y1, Y2, Y3, output, 1 each, registered pending bit i ANDed with ~mask[i]; these feed the 4-to-2 priority encoder directly.
REQ-009 Port ovf, output, 4, sticky overrun flag per line.
REQ-010 Port ovf_clr, input, 1, synchronous pulse that clears all ovf bits.

Function
REQ-011 Each req_in bit SHALL pass through a SYNC_STAGES flop synchronizer, followed by one history flop for rising-edge detection.
REQ-012 rise[i] SHALL equal sync_out[i] AND NOT hist[i]; only a 0->1 transition creates an event, and a held-high level creates exactly one event.
REQ-013 pend[i] SHALL set on the clock edge where rise[i]=1.
- With SYNC_STAGES=2, Y goes high after the 3rd rising clk edge at which req_in is sampled high.
REQ-014 pend[i] SHALL clear on an edge where ack=1 and ack_idx=i, unless rise[i]=1 on that same edge; in that case set wins and pend stays 1.
REQ-015 ack targeting a non-pending line SHALL change no state.
- ack affects only the single line selected by ack_idx.
REQ-016 Yi SHALL be a combinational AND of registered pend[i] with ~mask[i].
- Masking never clears pend.
- Unmasking a pending line SHALL assert Yi in the same cycle.
REQ-017 ovf[i] SHALL set when rise[i]=1 while pend[i]=1 and no same-edge ack clears line i.
- When the ack clears line i on that same edge, the event re-pends without overflow.
REQ-018 ovf_clr SHALL clear all ovf bits.
- If ovf_clr and an overflow condition on line i occur on the same edge, ovf[i] ends at 1.
REQ-019 Multiple lines MAY set, clear or overflow on the same edge independently.
- No arbitration is done here; priority is resolved downstream.
REQ-020 The block SHALL contain no combinational path from req_in to any output.

Reset
REQ-021 While rst_n=0, all synchronizer, history, pend and ovf flops SHALL be 0.
- Consequently Y0-Y3=0 and ovf=4'b0000 immediately, independent of clk.
REQ-022 After rst_n deasserts with req_in already high, line i SHALL register one event once the synchronizer fills.
- The history flop reset to 0 makes a held-high line appear as a fresh rise.
REQ-023 Reset asserted mid-operation SHALL discard all pending and overflow state; no event is retained across reset.

Structure
REQ-024 A shared package SHALL hold NUM_IRQ=4, IRQ_IDX_W=2 and the SYNC_STAGES default; the downstream encoder reuses them.
REQ-025 The synchronizer SHALL be a separate sub-module, sync_ff, parameterized on stage count, with one instance per line.
REQ-026 The per-line pend/ovf logic SHALL be generated from a loop over NUM_IRQ.

Verification
REQ-027 Reset, then req_in=4'b0100 for 1 cycle -> Y2=1 from the 3rd edge on, Y0/Y1/Y3=0, ovf=0; ack=1, ack_idx=2 -> Y2=0 the next cycle.
REQ-028 req_in=4'b1111 held 10 cycles -> all four Y=1 after 3 edges, each line pends exactly once, ovf=0.
REQ-029 Pend line 0, pulse req_in[0] a second time without ack -> ovf=4'b0001; ovf_clr -> ovf=0 while Y0 stays 1.
REQ-030 Pend line 1 with mask=4'b0010 -> Y1=0; mask=0 -> Y1=1 in the same cycle; ack with ack_idx=3 -> Y1 stays 1.
REQ-031 Time ack(ack_idx=3) on the same edge as a new rise[3] -> Y3 stays 1 and ovf[3]=0.
REQ-032 Pend lines 0 and 2, assert rst_n=0 mid-cycle -> Y and ovf go to 0 asynchronously; release with req_in=0 -> nothing pends.
